// File: rtl/ahb_to_reg_bridge_if.sv
// Purpose : bus bundle between an AHB slave front end and a register block, as seen by ahb_to_reg_bridge.
// Latency : wiring only, no logic.
// Backpressure: ahb_reg_hld stalls the AHB side; reg_busy stalls the bridge.
// Ports: AHB request (dv/write/size/addr/wdata), AHB response (hld/err/rdata),
//        register strobes (we/re/addr/wdata/be), register response (rdata/error/busy).
// Modports: slave = the bridge; master = the environment driving it (AHB side plus register block).
interface ahb_to_reg_bridge_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int DATA_BYTE_WIDTH = DATA_WIDTH / 8;

   // AHB side
   logic                       ahb_reg_dv;
   logic                       ahb_reg_write;
   logic [2:0]                 ahb_reg_size;
   logic [ADDR_WIDTH-1:0]      ahb_reg_addr;
   logic [DATA_WIDTH-1:0]      ahb_reg_wdata;
   logic                       ahb_reg_hld;
   logic                       ahb_reg_err;
   logic [DATA_WIDTH-1:0]      ahb_reg_rdata;

   // register block side
   logic                       reg_we;
   logic                       reg_re;
   logic [ADDR_WIDTH-1:0]      reg_addr;
   logic [DATA_WIDTH-1:0]      reg_wdata;
   logic [DATA_BYTE_WIDTH-1:0] reg_be;
   logic [DATA_WIDTH-1:0]      reg_rdata;
   logic                       reg_error;
   logic                       reg_busy;

   modport slave (
      input  ahb_reg_dv, ahb_reg_write, ahb_reg_size, ahb_reg_addr, ahb_reg_wdata,
      output ahb_reg_hld, ahb_reg_err, ahb_reg_rdata,
      output reg_we, reg_re, reg_addr, reg_wdata, reg_be,
      input  reg_rdata, reg_error, reg_busy
   );

   modport master (
      output ahb_reg_dv, ahb_reg_write, ahb_reg_size, ahb_reg_addr, ahb_reg_wdata,
      input  ahb_reg_hld, ahb_reg_err, ahb_reg_rdata,
      input  reg_we, reg_re, reg_addr, reg_wdata, reg_be,
      output reg_rdata, reg_error, reg_busy
   );
endinterface

// File: rtl/ahb_to_reg_bridge.sv
// Purpose : registered AHB-slave to register-block bridge with HSIZE/address byte-enable decode.
// Latency : 3+RD_LAT cycles from dv to next IDLE (IDLE, ACC, [LAT x RD_LAT], RESP) when reg_busy=0.
// Backpressure: ahb_reg_hld held through ACC/LAT; strobe held while reg_busy=1.
// Ports: clk, rst (synchronous, active-high), bus (ahb_to_reg_bridge_if.slave).
// Optional: define AHB_TO_REG_BRIDGE_TIMEOUT_EN to abort a strobe stalled by reg_busy for
//           TIMEOUT_CYCLES cycles with an error response and zero read data.
module ahb_to_reg_bridge #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH      = 32,
   parameter int RD_LAT          = 0,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic               clk,
   input  logic               rst,
   ahb_to_reg_bridge_if.slave bus
);

   localparam int         LANE_W   = $clog2(DATA_BYTE_WIDTH);
   localparam logic [2:0] MAX_SIZE = 3'(LANE_W);
   localparam logic [1:0] LAT_INIT = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || DATA_BYTE_WIDTH != DATA_WIDTH / 8 ||
       RD_LAT < 0 || RD_LAT > 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ahb_to_reg_bridge: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      LAT  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic                       write_q, write_d;
   logic [1:0]                 lat_q, lat_d;
   logic                       capture;
   logic                       resp_err_d;
   logic                       rdata_upd;
   logic [DATA_WIDTH-1:0]      resp_rdata_d;

   logic                       resp_err_q;
   logic [DATA_WIDTH-1:0]      rdata_q;
   logic                       we_q, re_q;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [DATA_WIDTH-1:0]      wdata_q;
   logic [DATA_BYTE_WIDTH-1:0] be_q;

   logic                       dec_err;
   logic [DATA_BYTE_WIDTH-1:0] dec_be;
   logic [LANE_W-1:0]          lane;

`ifdef AHB_TO_REG_BRIDGE_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]            to_q, to_d;
`endif

   // Size/alignment decode. A legal access covers 2^size lanes starting at the
   // lane selected by the low address bits; any set address bit below size is a
   // misalignment.
   always_comb begin
      lane    = bus.ahb_reg_addr[LANE_W-1:0];
      dec_err = 1'b0;
      dec_be  = '0;
      if (bus.ahb_reg_size > MAX_SIZE) begin
         dec_err = 1'b1;
      end else begin
         for (int i = 0; i < LANE_W; i++) begin
            if (i < int'(bus.ahb_reg_size) && lane[i]) dec_err = 1'b1;
         end
         for (int b = 0; b < DATA_BYTE_WIDTH; b++) begin
            dec_be[b] = (b >= int'(lane)) &&
                        (b < int'(lane) + (int'(1) << bus.ahb_reg_size));
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      lat_d        = lat_q;
      capture      = 1'b0;
      resp_err_d   = 1'b0;
      rdata_upd    = 1'b0;
      resp_rdata_d = rdata_q;
`ifdef AHB_TO_REG_BRIDGE_TIMEOUT_EN
      to_d         = to_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.ahb_reg_dv) begin
               if (dec_err) begin
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  rdata_upd    = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d = ACC;
                  capture = 1'b1;
                  write_d = bus.ahb_reg_write;
`ifdef AHB_TO_REG_BRIDGE_TIMEOUT_EN
                  to_d    = '0;
`endif
               end
            end
         end
         ACC: begin
            if (bus.reg_busy) begin
`ifdef AHB_TO_REG_BRIDGE_TIMEOUT_EN
               if (to_q == TO_LAST) begin
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  rdata_upd    = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  to_d = to_q + TO_W'(1);
               end
`else
               // No abort path: a stuck register block stalls the AHB side.
               state_d = ACC;
`endif
            end else if (write_q) begin
               state_d    = RESP;
               resp_err_d = bus.reg_error;
            end else if (RD_LAT == 0) begin
               state_d      = RESP;
               resp_err_d   = bus.reg_error;
               rdata_upd    = 1'b1;
               resp_rdata_d = bus.reg_rdata;
            end else begin
               state_d = LAT;
               lat_d   = LAT_INIT;
            end
         end
         LAT: begin
            if (lat_q == 2'd0) begin
               state_d      = RESP;
               resp_err_d   = bus.reg_error;
               rdata_upd    = 1'b1;
               resp_rdata_d = bus.reg_rdata;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         RESP: begin
            // dv still high here belongs to the finishing transfer.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         lat_q      <= 2'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         resp_err_q <= 1'b0;
         rdata_q    <= '0;
`ifdef AHB_TO_REG_BRIDGE_TIMEOUT_EN
         to_q       <= '0;
`endif
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         lat_q   <= lat_d;
         if (capture) begin
            addr_q  <= bus.ahb_reg_addr;
            wdata_q <= bus.ahb_reg_wdata;
            be_q    <= dec_be;
         end
         // Strobes follow the next state so they are high exactly for the ACC cycles.
         we_q       <= (state_d == ACC) && write_d;
         re_q       <= (state_d == ACC) && !write_d;
         // Only transitions into RESP set the error, so it is a one-cycle pulse.
         resp_err_q <= (state_d == RESP) && resp_err_d;
         if (rdata_upd) rdata_q <= resp_rdata_d;
`ifdef AHB_TO_REG_BRIDGE_TIMEOUT_EN
         to_q <= to_d;
`endif
      end
   end

   assign bus.ahb_reg_hld   = ((state_q == IDLE) && bus.ahb_reg_dv) ||
                              (state_q == ACC) || (state_q == LAT);
   assign bus.ahb_reg_err   = resp_err_q;
   assign bus.ahb_reg_rdata = rdata_q;
   assign bus.reg_we        = we_q;
   assign bus.reg_re        = re_q;
   assign bus.reg_addr      = addr_q;
   assign bus.reg_wdata     = wdata_q;
   assign bus.reg_be        = be_q;

endmodule

// File: tb/tb_ahb_to_reg_bridge.sv
module tb_ahb_to_reg_bridge;
   localparam int RD_LAT32 = 1;
   localparam int RD_LAT64 = 0;
   localparam int TO_CYC   = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ahb_to_reg_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
   ahb_to_reg_bridge_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();

   ahb_to_reg_bridge #(.DATA_WIDTH(32), .DATA_BYTE_WIDTH(4), .ADDR_WIDTH(32),
                       .RD_LAT(RD_LAT32), .TIMEOUT_CYCLES(TO_CYC))
      dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
   ahb_to_reg_bridge #(.DATA_WIDTH(64), .DATA_BYTE_WIDTH(8), .ADDR_WIDTH(32),
                       .RD_LAT(RD_LAT64), .TIMEOUT_CYCLES(TO_CYC))
      dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // sampled outputs
   logic        s_we, s_re, s_hld, s_err;
   logic [7:0]  s_be;
   logic [31:0] s_addr;
   logic [63:0] s_wdata, s_rdata;

   // per-transfer observations
   int          obs_we, obs_re, obs_hld, obs_errc, obs_post_strobe;
   bit          obs_timeout, obs_err;
   logic [7:0]  obs_be;
   logic [31:0] obs_addr;
   logic [63:0] obs_wdata, obs_rdata;

   // reference model state and expectations
   logic [63:0] model_rdata [2];
   int          exp_we, exp_re, exp_hld;
   bit          exp_err, exp_dec_err;
   logic [7:0]  exp_be;
   logic [63:0] exp_rdata;

   task automatic drive_req(input bit sel, input logic dv, input logic write, input logic [2:0] size,
                            input logic [31:0] addr, input logic [63:0] wdata);
      if (sel) begin
         b64.ahb_reg_dv = dv; b64.ahb_reg_write = write; b64.ahb_reg_size = size;
         b64.ahb_reg_addr = addr; b64.ahb_reg_wdata = wdata;
      end else begin
         b32.ahb_reg_dv = dv; b32.ahb_reg_write = write; b32.ahb_reg_size = size;
         b32.ahb_reg_addr = addr; b32.ahb_reg_wdata = wdata[31:0];
      end
   endtask

   task automatic drive_reg(input bit sel, input logic busy, input logic err, input logic [63:0] rdata);
      if (sel) begin
         b64.reg_busy = busy; b64.reg_error = err; b64.reg_rdata = rdata;
      end else begin
         b32.reg_busy = busy; b32.reg_error = err; b32.reg_rdata = rdata[31:0];
      end
   endtask

   task automatic sample(input bit sel);
      if (sel) begin
         s_we = b64.reg_we; s_re = b64.reg_re; s_hld = b64.ahb_reg_hld; s_err = b64.ahb_reg_err;
         s_be = b64.reg_be; s_addr = b64.reg_addr; s_wdata = b64.reg_wdata; s_rdata = b64.ahb_reg_rdata;
      end else begin
         s_we = b32.reg_we; s_re = b32.reg_re; s_hld = b32.ahb_reg_hld; s_err = b32.ahb_reg_err;
         s_be = 8'(b32.reg_be); s_addr = b32.reg_addr; s_wdata = 64'(b32.reg_wdata);
         s_rdata = 64'(b32.ahb_reg_rdata);
      end
   endtask

   // Runs one AHB transfer; register block reports busy for the first busy_n strobe cycles.
   task automatic run_xfer(input bit sel, input bit write, input logic [2:0] size, input logic [31:0] addr,
                           input logic [63:0] wdata, input int busy_n, input bit rerr,
                           input logic [63:0] rdata, input int max_cyc, input bit keep_dv);
      int  strobes = 0;
      bit  done = 0;
      obs_we = 0; obs_re = 0; obs_hld = 0; obs_errc = 0; obs_post_strobe = 0;
      obs_timeout = 0; obs_err = 0; obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_rdata = '0;
      @(negedge clk);
      drive_req(sel, 1'b1, write, size, addr, wdata);
      drive_reg(sel, 1'b0, rerr, rdata);
      for (int c = 0; c < max_cyc && !done; c++) begin
         #1;
         sample(sel);
         if (s_we) obs_we++;
         if (s_re) obs_re++;
         if (s_err) obs_errc++;
         if (s_we || s_re) begin
            obs_be = s_be; obs_addr = s_addr; obs_wdata = s_wdata;
            strobes++;
            drive_reg(sel, strobes <= busy_n, rerr, rdata);
         end else begin
            drive_reg(sel, 1'b0, rerr, rdata);
         end
         if (s_hld) begin
            obs_hld++;
         end else begin
            done = 1;
            obs_rdata = s_rdata;
            obs_err = s_err;
            if (!keep_dv) drive_req(sel, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
         end
         @(negedge clk);
      end
      if (!done) begin
         obs_timeout = 1;
      end else begin
         drive_req(sel, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
         for (int c = 0; c < 3; c++) begin
            #1;
            sample(sel);
            if (s_err) obs_errc++;
            if (s_we || s_re) obs_post_strobe++;
            @(negedge clk);
         end
      end
   endtask

   // Expected outcome from the rules: 2^size bytes, aligned, within the bus; one IDLE
   // cycle of hold, one strobe cycle per busy cycle plus the accept, RD_LAT for reads.
   task automatic model_xfer(input bit sel, input bit write, input logic [2:0] size, input logic [31:0] addr,
                             input int busy_n, input bit rerr, input logic [63:0] rdata);
      int unsigned dbw = sel ? 8 : 4;
      int          lat = sel ? RD_LAT64 : RD_LAT32;
      int unsigned nb  = 1 << size;
      exp_dec_err = (nb > dbw) || ((addr % nb) != 0);
      exp_be      = exp_dec_err ? 8'h00 : 8'(((1 << nb) - 1) << (addr % dbw));
      exp_hld     = exp_dec_err ? 1 : 2 + busy_n + (write ? 0 : lat);
      exp_we      = (!exp_dec_err && write) ? busy_n + 1 : 0;
      exp_re      = (!exp_dec_err && !write) ? busy_n + 1 : 0;
      exp_err     = exp_dec_err | rerr;
      if (exp_dec_err) model_rdata[sel] = 64'd0;
      else if (!write) model_rdata[sel] = sel ? rdata : {32'd0, rdata[31:0]};
      exp_rdata = model_rdata[sel];
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive_req(0, 0, 0, 0, 0, 0); drive_req(1, 0, 0, 0, 0, 0);
      drive_reg(0, 0, 0, 0);       drive_reg(1, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      model_rdata[0] = 0; model_rdata[1] = 0;
      #1;
      for (int s = 0; s < 2; s++) begin
         sample(s[0]);
         n_checks++; if ({s_we, s_re, s_hld, s_err} !== 4'b0) begin n_fail++;
            $display("FAIL reset_ctrl dut%0d: we/re/hld/err=%b required 0000", s, {s_we, s_re, s_hld, s_err}); end
         n_checks++; if (s_rdata !== 64'd0 || s_be !== 8'd0 || s_addr !== 32'd0) begin n_fail++;
            $display("FAIL reset_data dut%0d: rdata=%h be=%h addr=%h required 0", s, s_rdata, s_be, s_addr); end
      end
   endtask

   task automatic test_word_write;
      model_xfer(0, 1, 3'd2, 32'h10, 0, 0, 64'd0);
      run_xfer(0, 1, 3'd2, 32'h10, 64'hDEADBEEF, 0, 0, 64'd0, 20, 0);
      n_checks++; if (obs_we !== 1 || obs_re !== 0) begin n_fail++;
         $display("FAIL word_write_strobe: we=%0d re=%0d required 1 0", obs_we, obs_re); end
      n_checks++; if (obs_be !== 8'h0F || obs_wdata !== 64'hDEADBEEF || obs_addr !== 32'h10) begin n_fail++;
         $display("FAIL word_write_data: be=%h wdata=%h addr=%h required 0f deadbeef 10", obs_be, obs_wdata, obs_addr); end
      n_checks++; if (obs_hld !== 2 || obs_errc !== 0) begin n_fail++;
         $display("FAIL word_write_resp: hld=%0d errcyc=%0d required 2 0", obs_hld, obs_errc); end
   endtask

   task automatic test_byte_read;
      model_xfer(0, 0, 3'd0, 32'h13, 0, 0, 64'hAABBCCDD);
      run_xfer(0, 0, 3'd0, 32'h13, 64'd0, 0, 0, 64'hAABBCCDD, 20, 0);
      n_checks++; if (obs_re !== 1 || obs_we !== 0 || obs_be !== 8'h08) begin n_fail++;
         $display("FAIL byte_read_strobe: re=%0d we=%0d be=%h required 1 0 08", obs_re, obs_we, obs_be); end
      n_checks++; if (obs_rdata !== 64'hAABBCCDD || obs_hld !== 3 || obs_err !== 0) begin n_fail++;
         $display("FAIL byte_read_resp: rdata=%h hld=%0d err=%b required aabbccdd 3 0", obs_rdata, obs_hld, obs_err); end
   endtask

   task automatic test_decode_error;
      model_xfer(0, 0, 3'd1, 32'h1, 0, 0, 64'h12345678);
      run_xfer(0, 0, 3'd1, 32'h1, 64'd0, 0, 0, 64'h12345678, 20, 0);
      n_checks++; if (obs_we !== 0 || obs_re !== 0) begin n_fail++;
         $display("FAIL misalign_strobe: we=%0d re=%0d required 0 0", obs_we, obs_re); end
      n_checks++; if (obs_err !== 1 || obs_errc !== 1 || obs_rdata !== 64'd0 || obs_hld !== 1) begin n_fail++;
         $display("FAIL misalign_resp: err=%b errcyc=%0d rdata=%h hld=%0d required 1 1 0 1",
                  obs_err, obs_errc, obs_rdata, obs_hld); end
      model_xfer(0, 1, 3'd3, 32'h8, 0, 0, 64'd0);
      run_xfer(0, 1, 3'd3, 32'h8, 64'h1, 0, 0, 64'd0, 20, 0);
      n_checks++; if (obs_we !== 0 || obs_err !== 1 || obs_errc !== 1) begin n_fail++;
         $display("FAIL size3_on_32: we=%0d err=%b errcyc=%0d required 0 1 1", obs_we, obs_err, obs_errc); end
   endtask

   task automatic test_busy_write;
      run_xfer(0, 1, 3'd2, 32'h40, 64'h0BADF00D, 5, 0, 64'd0, 30, 0);
      n_checks++; if (obs_we !== 6 || obs_hld !== 7 || obs_errc !== 0) begin n_fail++;
         $display("FAIL busy_write: we=%0d hld=%0d errcyc=%0d required 6 7 0", obs_we, obs_hld, obs_errc); end
   endtask

   task automatic test_dword64;
      model_xfer(1, 1, 3'd3, 32'h8, 0, 0, 64'd0);
      run_xfer(1, 1, 3'd3, 32'h8, 64'h0123456789ABCDEF, 0, 0, 64'd0, 20, 0);
      n_checks++; if (obs_be !== 8'hFF || obs_wdata !== 64'h0123456789ABCDEF || obs_we !== 1) begin n_fail++;
         $display("FAIL dword64_write: be=%h wdata=%h we=%0d required ff 0123456789abcdef 1", obs_be, obs_wdata, obs_we); end
      model_xfer(1, 0, 3'd3, 32'h10, 0, 0, 64'hFEEDFACECAFEBABE);
      run_xfer(1, 0, 3'd3, 32'h10, 64'd0, 0, 0, 64'hFEEDFACECAFEBABE, 20, 0);
      n_checks++; if (obs_rdata !== exp_rdata || obs_hld !== exp_hld || obs_re !== 1) begin n_fail++;
         $display("FAIL dword64_read: rdata=%h hld=%0d re=%0d required %h %0d 1", obs_rdata, obs_hld, obs_re, exp_rdata, exp_hld); end
   endtask

   task automatic test_resp_dv_ignored;
      run_xfer(0, 1, 3'd2, 32'h20, 64'h55, 0, 0, 64'd0, 20, 1);
      n_checks++; if (obs_we !== 1 || obs_post_strobe !== 0) begin n_fail++;
         $display("FAIL resp_dv_ignored: we=%0d strobes_after=%0d required 1 0", obs_we, obs_post_strobe); end
   endtask

   task automatic test_random;
      for (int n = 0; n < 60; n++) begin
         bit          sel   = 1'($urandom_range(0, 1));
         bit          write = 1'($urandom_range(0, 1));
         logic [2:0]  size  = 3'($urandom_range(0, 3));
         logic [31:0] addr  = $urandom;
         logic [63:0] wdata = {$urandom, $urandom};
         logic [63:0] rdata = {$urandom, $urandom};
         int          busy  = $urandom_range(0, 3);
         bit          rerr  = ($urandom_range(0, 7) == 0);
         logic [31:0] mask  = (32'd1 << size) - 32'd1;
         if ($urandom_range(0, 3) != 0) addr = addr & ~mask;
         model_xfer(sel, write, size, addr, busy, rerr, rdata);
         run_xfer(sel, write, size, addr, wdata, busy, rerr, rdata, 30, 0);
         n_checks++; if (obs_timeout !== 0 || obs_hld !== exp_hld) begin n_fail++;
            $display("FAIL rnd%0d_hold: timeout=%b hld=%0d required 0 %0d", n, obs_timeout, obs_hld, exp_hld); end
         n_checks++; if (obs_we !== exp_we || obs_re !== exp_re) begin n_fail++;
            $display("FAIL rnd%0d_strobe: we=%0d re=%0d required %0d %0d", n, obs_we, obs_re, exp_we, exp_re); end
         n_checks++; if (obs_err !== exp_err || obs_errc !== int'(exp_err)) begin n_fail++;
            $display("FAIL rnd%0d_err: err=%b errcyc=%0d required %b", n, obs_err, obs_errc, exp_err); end
         n_checks++; if (obs_rdata !== exp_rdata) begin n_fail++;
            $display("FAIL rnd%0d_rdata: rdata=%h required %h", n, obs_rdata, exp_rdata); end
         if (!exp_dec_err) begin
            n_checks++;
            if (obs_be !== exp_be || obs_addr !== addr || obs_wdata !== (sel ? wdata : {32'd0, wdata[31:0]})) begin
               n_fail++;
               $display("FAIL rnd%0d_capture: be=%h addr=%h wdata=%h required be=%h addr=%h",
                        n, obs_be, obs_addr, obs_wdata, exp_be, addr);
            end
         end
      end
   endtask

   task automatic apply_reset_from_acc(input string tag);
      rst = 1'b1;
      drive_req(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      sample(0);
      n_checks++; if ({s_we, s_re, s_hld, s_err} !== 4'b0) begin n_fail++;
         $display("FAIL %s_abort: we/re/hld/err=%b required 0000", tag, {s_we, s_re, s_hld, s_err}); end
      model_rdata[0] = 0; model_rdata[1] = 0;
      @(negedge clk); rst = 1'b0; drive_reg(0, 0, 0, 0);
      @(posedge clk); #1;
      sample(0);
      n_checks++; if (s_err !== 1'b0 || s_hld !== 1'b0 || s_rdata !== model_rdata[0]) begin n_fail++;
         $display("FAIL %s_after: err=%b hld=%b rdata=%h required 0 0 0", tag, s_err, s_hld, s_rdata); end
   endtask

   task automatic test_timeout;
`ifdef AHB_TO_REG_BRIDGE_TIMEOUT_EN
      run_xfer(0, 0, 3'd2, 32'h30, 64'd0, 1000, 0, 64'h77777777, 60, 0);
      n_checks++; if (obs_timeout !== 0 || obs_re !== TO_CYC || obs_hld !== TO_CYC + 1) begin n_fail++;
         $display("FAIL timeout_strobe: stuck=%b re=%0d hld=%0d required 0 %0d %0d",
                  obs_timeout, obs_re, obs_hld, TO_CYC, TO_CYC + 1); end
      model_rdata[0] = 0;
      n_checks++; if (obs_err !== 1 || obs_errc !== 1 || obs_rdata !== model_rdata[0]) begin n_fail++;
         $display("FAIL timeout_resp: err=%b errcyc=%0d rdata=%h required 1 1 0", obs_err, obs_errc, obs_rdata); end
`else
      run_xfer(0, 1, 3'd2, 32'h30, 64'h9, 1000, 0, 64'd0, 40, 0);
      n_checks++; if (obs_timeout !== 1 || obs_hld !== 40 || obs_we !== 39 || obs_errc !== 0) begin n_fail++;
         $display("FAIL stuck_busy_hold: stuck=%b hld=%0d we=%0d errcyc=%0d required 1 40 39 0",
                  obs_timeout, obs_hld, obs_we, obs_errc); end
      apply_reset_from_acc("stuck_recover");
`endif
   endtask

   task automatic test_reset_mid;
      run_xfer(0, 1, 3'd2, 32'h24, 64'hABCD, 1000, 0, 64'd0, 4, 0);
      n_checks++; if (obs_timeout !== 1 || obs_we !== 3) begin n_fail++;
         $display("FAIL reset_mid_setup: in_acc=%b we=%0d required 1 3", obs_timeout, obs_we); end
      apply_reset_from_acc("reset_mid");
   endtask

   initial begin
      test_reset();
      test_word_write();
      test_byte_read();
      test_decode_error();
      test_busy_write();
      test_dword64();
      test_resp_dv_ignored();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
